// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared branch codes, defaults and decode helper for pc_sequencer
package pc_sequencer_pkg;

  localparam int DEF_PC_W = 13;
  localparam int DEF_STACK_DEPTH = 8;
  localparam logic [12:0] DEF_INT_VECTOR = 13'h004;

  localparam logic [1:0] PH_Q4 = 2'd3;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_GOTO = 3'd1,
    BR_CALL = 3'd2,
    BR_RET  = 3'd3,
    BR_SKIP = 3'd4
  } br_type_e;

  // Codes 5..7 are reserved by the decoder and behave as a plain fall-through.
  function automatic br_type_e decode_br(input logic [2:0] raw);
    case (raw)
      3'd1:    return BR_GOTO;
      3'd2:    return BR_CALL;
      3'd3:    return BR_RET;
      3'd4:    return BR_SKIP;
      default: return BR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_call_stack.sv
// rtl/pc_sequencer_call_stack.sv - circular hardware call stack with combinational pop data
module pc_sequencer_call_stack
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_PC_W,
  parameter int DEPTH = DEF_STACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [PTR_W-1:0] ptr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Pointer wraps silently in both directions; overflow overwrites the oldest entry.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d = ptr_q + 1'b1;
    end else if (pop) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[ptr_q - 1'b1];
  assign ptr      = ptr_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Q1..Q4 phase generator and next-PC decision for program_counter
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W        = DEF_PC_W,
  parameter int              STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [PC_W-1:0] INT_VECTOR  = DEF_INT_VECTOR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [2:0]                     br_type,
  input  logic [10:0]                    br_target,
  input  logic [4:0]                     pclath_in,
  input  logic [PC_W-1:0]                pc_in,
  input  logic                           int_req,
  output logic [1:0]                     q_phase,
  output logic                           incr_pc_en,
  output logic                           pc_load_en,
  output logic [PC_W-1:0]                pc_load_val,
  output logic                           flush,
  output logic                           int_ack,
  output logic [$clog2(STACK_DEPTH)-1:0] stk_ptr
);

  logic [1:0]      phase_q, phase_d;
  logic            flush_q, flush_d;
  logic            incr_q, incr_d;
  logic            load_q, load_d;
  logic            ack_q, ack_d;
  logic [PC_W-1:0] load_val_q, load_val_d;

  logic            stk_push, stk_pop;
  logic [PC_W-1:0] stk_pop_data;
  logic [PC_W-1:0] goto_addr;
  br_type_e        br;
  logic            unused_pclath;

  assign goto_addr     = PC_W'({pclath_in[4:3], br_target});
  assign br            = decode_br(br_type);
  assign unused_pclath = ^pclath_in[2:0];

  pc_sequencer_call_stack #(
    .WIDTH (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_in),
    .pop_data  (stk_pop_data),
    .ptr       (stk_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      flush_q    <= 1'b1;
      incr_q     <= 1'b0;
      load_q     <= 1'b0;
      ack_q      <= 1'b0;
      load_val_q <= '0;
    end else begin
      phase_q    <= phase_d;
      flush_q    <= flush_d;
      incr_q     <= incr_d;
      load_q     <= load_d;
      ack_q      <= ack_d;
      load_val_q <= load_val_d;
    end
  end

  // Everything holds while en=0, so a frozen Q1 pulse is re-presented once en returns.
  always_comb begin
    phase_d    = phase_q;
    flush_d    = flush_q;
    incr_d     = incr_q;
    load_d     = load_q;
    ack_d      = ack_q;
    load_val_d = load_val_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    if (en) begin
      phase_d = phase_q + 2'd1;
      incr_d  = 1'b0;
      load_d  = 1'b0;
      ack_d   = 1'b0;
      if (phase_q == PH_Q4) begin
        if (flush_q) begin
          incr_d  = 1'b1;
          flush_d = 1'b0;
        end else begin
          case (br)
            BR_NONE: begin
              if (int_req) begin
                stk_push   = 1'b1;
                load_d     = 1'b1;
                load_val_d = INT_VECTOR;
                ack_d      = 1'b1;
                flush_d    = 1'b1;
              end else begin
                incr_d  = 1'b1;
                flush_d = 1'b0;
              end
            end
            BR_GOTO: begin
              load_d     = 1'b1;
              load_val_d = goto_addr;
              flush_d    = 1'b1;
            end
            BR_CALL: begin
              stk_push   = 1'b1;
              load_d     = 1'b1;
              load_val_d = goto_addr;
              flush_d    = 1'b1;
            end
            BR_RET: begin
              stk_pop    = 1'b1;
              load_d     = 1'b1;
              load_val_d = stk_pop_data;
              flush_d    = 1'b1;
            end
            BR_SKIP: begin
              incr_d  = 1'b1;
              flush_d = 1'b1;
            end
            default: begin
              incr_d  = 1'b1;
              flush_d = 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign q_phase     = phase_q;
  assign flush       = flush_q;
  assign pc_load_val = load_val_q;
  assign incr_pc_en  = incr_q & en;
  assign pc_load_en  = load_q & en;
  assign int_ack     = ack_q & en;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed table-driven bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [2:0] N = 3'd0, G = 3'd1, C = 3'd2, R = 3'd3, S = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [2:0]  br_type = 3'd0;
  logic [10:0] br_target = '0;
  logic [4:0]  pclath_in = '0;
  logic [12:0] pc_in = '0;
  logic        int_req = 1'b0;
  logic [1:0]  q_phase;
  logic        incr_pc_en, pc_load_en, flush, int_ack;
  logic [12:0] pc_load_val;
  logic [2:0]  stk_ptr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  br;
    logic [10:0] tgt;
    logic [4:0]  pl;
    logic [12:0] pc;
    logic        irq;
    logic        e_incr;
    logic        e_load;
    logic [12:0] e_val;
    logic        e_flush;
    logic        e_ack;
    logic [2:0]  e_sp;
  } vec_t;

  vec_t tbl [23];

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .br_type     (br_type),
    .br_target   (br_target),
    .pclath_in   (pclath_in),
    .pc_in       (pc_in),
    .int_req     (int_req),
    .q_phase     (q_phase),
    .incr_pc_en  (incr_pc_en),
    .pc_load_en  (pc_load_en),
    .pc_load_val (pc_load_val),
    .flush       (flush),
    .int_ack     (int_ack),
    .stk_ptr     (stk_ptr)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] br, input logic [10:0] tgt, input logic [4:0] pl,
                              input logic [12:0] pc, input logic irq, input logic ei, input logic el,
                              input logic [12:0] ev, input logic ef, input logic ea, input logic [2:0] es);
    vec_t v;
    v.br = br; v.tgt = tgt; v.pl = pl; v.pc = pc; v.irq = irq;
    v.e_incr = ei; v.e_load = el; v.e_val = ev; v.e_flush = ef; v.e_ack = ea; v.e_sp = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Entered at a Q1 negedge; returns at the next Q1 negedge after checking the decision.
  task automatic run_cycle(input vec_t v, input string tag);
    logic bad;
    br_type = v.br; br_target = v.tgt; pclath_in = v.pl; pc_in = v.pc; int_req = v.irq;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (incr_pc_en || pc_load_en || int_ack) bad = 1'b1;
    end
    @(negedge clk);
    chk({tag, ".quiet_q2q4"}, 32'(bad), 32'd0);
    chk({tag, ".phase"}, 32'(q_phase), 32'd0);
    chk({tag, ".incr"}, 32'(incr_pc_en), 32'(v.e_incr));
    chk({tag, ".load"}, 32'(pc_load_en), 32'(v.e_load));
    if (v.e_load) chk({tag, ".val"}, 32'(pc_load_val), 32'(v.e_val));
    chk({tag, ".flush"}, 32'(flush), 32'(v.e_flush));
    chk({tag, ".ack"}, 32'(int_ack), 32'(v.e_ack));
    chk({tag, ".sp"}, 32'(stk_ptr), 32'(v.e_sp));
    chk({tag, ".excl"}, 32'(incr_pc_en & pc_load_en), 32'd0);
  endtask

  initial begin
    logic [12:0] ret_vals [9];
    ret_vals = '{13'd9, 13'd8, 13'd7, 13'd6, 13'd5, 13'd4, 13'd3, 13'd2, 13'd9};

    //            br  tgt      pl        pc        irq   incr  load  val       flush ack   sp
    tbl[0]  = mk(N, 11'h000, 5'b00000, 13'h0000, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[1]  = mk(N, 11'h000, 5'b00000, 13'h0001, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[2]  = mk(G, 11'h123, 5'b11000, 13'h0002, 1'b0, 1'b0, 1'b1, 13'h1923, 1'b1, 1'b0, 3'd0);
    tbl[3]  = mk(N, 11'h000, 5'b00000, 13'h1924, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[4]  = mk(C, 11'h010, 5'b00000, 13'h0050, 1'b0, 1'b0, 1'b1, 13'h0010, 1'b1, 1'b0, 3'd1);
    tbl[5]  = mk(N, 11'h000, 5'b00000, 13'h0011, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd1);
    tbl[6]  = mk(R, 11'h000, 5'b00000, 13'h0012, 1'b0, 1'b0, 1'b1, 13'h0050, 1'b1, 1'b0, 3'd0);
    tbl[7]  = mk(N, 11'h000, 5'b00000, 13'h0051, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[8]  = mk(G, 11'h200, 5'b00000, 13'h0052, 1'b1, 1'b0, 1'b1, 13'h0200, 1'b1, 1'b0, 3'd0);
    tbl[9]  = mk(N, 11'h000, 5'b00000, 13'h0200, 1'b1, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[10] = mk(N, 11'h000, 5'b00000, 13'h0201, 1'b1, 1'b0, 1'b1, 13'h0004, 1'b1, 1'b1, 3'd1);
    tbl[11] = mk(N, 11'h000, 5'b00000, 13'h0005, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd1);
    tbl[12] = mk(R, 11'h000, 5'b00000, 13'h0006, 1'b0, 1'b0, 1'b1, 13'h0201, 1'b1, 1'b0, 3'd0);
    tbl[13] = mk(N, 11'h000, 5'b00000, 13'h0202, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[14] = mk(S, 11'h000, 5'b00000, 13'h0203, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b1, 1'b0, 3'd0);
    tbl[15] = mk(G, 11'h7FF, 5'b11111, 13'h0204, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[16] = mk(3'd5, 11'h3AA, 5'b11000, 13'h0205, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[17] = mk(3'd7, 11'h155, 5'b01000, 13'h0ABC, 1'b1, 1'b0, 1'b1, 13'h0004, 1'b1, 1'b1, 3'd1);
    tbl[18] = mk(N, 11'h000, 5'b00000, 13'h0005, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd1);
    tbl[19] = mk(R, 11'h000, 5'b00000, 13'h0006, 1'b0, 1'b0, 1'b1, 13'h0ABC, 1'b1, 1'b0, 3'd0);
    tbl[20] = mk(N, 11'h000, 5'b00000, 13'h0ABD, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);
    tbl[21] = mk(G, 11'h000, 5'b01111, 13'h0ABE, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b1, 1'b0, 3'd0);
    tbl[22] = mk(N, 11'h000, 5'b00000, 13'h0801, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0);

    @(negedge clk);
    chk("rst.phase", 32'(q_phase), 32'd0);
    chk("rst.flush", 32'(flush), 32'd1);
    chk("rst.pulses", 32'({incr_pc_en, pc_load_en, int_ack}), 32'd0);
    chk("rst.val", 32'(pc_load_val), 32'd0);
    chk("rst.sp", 32'(stk_ptr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) run_cycle(tbl[i], $sformatf("v%0d", i));

    // Nine nested calls overflow the eight-entry stack.
    for (int i = 1; i <= 9; i++) begin
      run_cycle(mk(C, 11'h100, 5'b00000, 13'(i), 1'b0, 1'b0, 1'b1, 13'h0100, 1'b1, 1'b0, 3'(i)),
                $sformatf("call%0d", i));
      run_cycle(mk(N, 11'h000, 5'b00000, 13'h0101, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'(i)),
                $sformatf("call%0d_nop", i));
    end
    for (int j = 1; j <= 9; j++) begin
      run_cycle(mk(R, 11'h000, 5'b00000, 13'h0101, 1'b0, 1'b0, 1'b1, ret_vals[j-1], 1'b1, 1'b0, 3'(1 - j)),
                $sformatf("ret%0d", j));
      run_cycle(mk(N, 11'h000, 5'b00000, 13'h0000, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'(1 - j)),
                $sformatf("ret%0d_nop", j));
    end

    // Freeze for five clocks while the Q1 increment pulse is pending.
    en = 1'b0;
    #1;
    chk("frz.incr_gated", 32'(incr_pc_en), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("frz.phase", 32'(q_phase), 32'd0);
      chk("frz.pulses", 32'({incr_pc_en, pc_load_en, int_ack}), 32'd0);
    end
    en = 1'b1;
    #1;
    chk("frz.resume_incr", 32'(incr_pc_en), 32'd1);
    run_cycle(mk(N, 11'h000, 5'b00000, 13'h0002, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 3'd0), "frz.next");

    // Reset asserted while a CALL load pulse is live in Q1.
    run_cycle(mk(C, 11'h044, 5'b00000, 13'h0333, 1'b0, 1'b0, 1'b1, 13'h0044, 1'b1, 1'b0, 3'd1), "pre_rst");
    rst = 1'b1;
    #1;
    chk("mid_rst.load", 32'(pc_load_en), 32'd0);
    chk("mid_rst.flush", 32'(flush), 32'd1);
    chk("mid_rst.sp", 32'(stk_ptr), 32'd0);
    chk("mid_rst.val", 32'(pc_load_val), 32'd0);
    chk("mid_rst.phase", 32'(q_phase), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
